// File: rtl/sync_pulse_meter.sv
// Measures the length of each high/low phase between accepted edge pulses
// and queues {level, length} results in a small FIFO for a downstream consumer.
module sync_pulse_meter #(
  parameter int CNT_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 serial_i,
  input  logic                 r_edge_i,
  input  logic                 f_edge_i,
  output logic                 meas_valid_o,
  input  logic                 meas_ready_i,
  output logic [CNT_WIDTH-1:0] meas_len_o,
  output logic                 meas_level_o,
  output logic                 overflow_o
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [AW:0]          FULL_CNT = (AW+1)'(DEPTH);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic rise_ok, fall_ok, edge_evt, push, pop, full, wr_en;

  // An edge only counts when exactly one pulse fires and it agrees with the
  // synchronized level; anything else is treated as a glitch and ignored.
  assign rise_ok  = r_edge_i & ~f_edge_i & serial_i;
  assign fall_ok  = f_edge_i & ~r_edge_i & ~serial_i;
  assign edge_evt = en_i & (rise_ok | fall_ok);

  assign push  = edge_evt & (state == MEASURE);
  assign full  = (count == FULL_CNT);
  assign pop   = meas_valid_o & meas_ready_i;
  assign wr_en = push & (~full | pop) & ~clr_i;

  assign meas_valid_o = (count != '0);
  assign meas_len_o   = meas_valid_o ? mem[rd_ptr][CNT_WIDTH-1:0] : '0;
  assign meas_level_o = meas_valid_o ? mem[rd_ptr][CNT_WIDTH] : 1'b0;

  // Phase tracker: the first edge after IDLE only arms the counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (clr_i || !en_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (edge_evt) begin
      state <= MEASURE;
      cnt   <= CNT_WIDTH'(1);
    end else if (state == MEASURE && cnt != CNT_MAX) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // Ending a low phase is signalled by a rising edge, hence level = fall_ok.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= {fall_ok, cnt};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else if (clr_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !wr_en) begin
        count <= count - (AW+1)'(1);
      end
      if (push && full && !pop) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sync_pulse_meter.md
SYNC_PULSE_METER -- requirements
Module: sync_pulse_meter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the phase-length counter and of meas_len_o (legal range 4..32).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of measurement buffer entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port clr_i  input  1  synchronous clear.
REQ-006 SHALL have port en_i  input  1  measurement enable.
REQ-007 SHALL have port serial_i  input  1  synchronized level, the serial_o output of the upstream edge-detect stage.
REQ-008 SHALL have port r_edge_i  input  1  single-cycle rising-edge pulse from the upstream stage.
REQ-009 SHALL have port f_edge_i  input  1  single-cycle falling-edge pulse from the upstream stage.
REQ-010 SHALL have port meas_valid_o  output  1  a measurement is available at the buffer head.
REQ-011 SHALL have port meas_ready_i  input  1  consumer accepts the head measurement.
REQ-012 SHALL have port meas_len_o  output  CNT_WIDTH  length of the completed phase, in clk_i cycles.
REQ-013 SHALL have port meas_level_o  output  1  level of the completed phase (1 = high, 0 = low).
REQ-014 SHALL have port overflow_o  output  1  sticky flag: a measurement was dropped.

Function
REQ-015 SHALL implement states IDLE (no reference edge yet) and MEASURE (counting since the last accepted edge).
REQ-016 Edge event SHALL mean en_i=1 and exactly one of r_edge_i/f_edge_i asserted; both asserted together SHALL be ignored (no push, no state change, counter keeps counting).
REQ-017 IDLE + edge event -> MEASURE with counter loaded to 1; no push (first phase has unknown start and is discarded).
REQ-018 In MEASURE, each en_i=1 cycle without an edge event SHALL increment the counter, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-019 In MEASURE, an edge event SHALL push {level, counter value} and reload the counter to 1; level = 0 for r_edge_i, 1 for f_edge_i.
REQ-020 The phase length SHALL equal t1-t0 for consecutive edge events at cycles t0 and t1.
REQ-021 en_i=0 SHALL force IDLE and counter 0 on the next clock and ignore edges, while the buffer continues to drain.
REQ-022 The buffer SHALL be a FIFO of DEPTH entries; meas_valid_o = not empty; meas_len_o/meas_level_o SHALL show the head entry and stay stable while meas_valid_o=1 and meas_ready_i=0.
REQ-023 A pop SHALL occur on meas_valid_o & meas_ready_i.
REQ-024 Push latency SHALL be one cycle: edge event at cycle t into an empty FIFO -> meas_valid_o=1 at t+1.
REQ-025 Push while full without a same-cycle pop SHALL drop the new entry, keep FIFO contents, and set overflow_o from the next cycle.
REQ-026 Push while full with a same-cycle pop SHALL be accepted (occupancy unchanged).
REQ-027 meas_ready_i while empty SHALL have no effect.
REQ-028 serial_i SHALL be used only for the assertion that the edge direction matches serial_i (r_edge_i implies serial_i=1); a mismatch SHALL be treated as REQ-016 (ignored).
REQ-029 clr_i SHALL, on the next clock, empty the FIFO, clear overflow_o, set counter 0 and state IDLE, with priority over all other events, including a same-cycle edge event.

Reset
REQ-030 While rst_ni=0: state IDLE, counter 0, FIFO empty, meas_valid_o=0, meas_len_o=0, meas_level_o=0, overflow_o=0.
REQ-031 Reset asserted mid-measurement SHALL discard all pending entries; the first edge after release SHALL be treated as in REQ-017.

Verification
REQ-032 en_i=1, edges rise@10, fall@15, rise@22 -> pushes {1,5}@16 and {0,7}@23, meas_ready_i=1 throughout.
REQ-033 DEPTH=4, meas_ready_i=0, 6 edge events 3 cycles apart -> 4 entries of length 3 retained, overflow_o=1 after the 6th event, first entry unchanged at head.
REQ-034 CNT_WIDTH=4, edges 20 cycles apart -> meas_len_o=15 (saturated), no wrap.
REQ-035 Full FIFO, push and pop in the same cycle -> entry accepted, overflow_o stays 0, occupancy stays 4.
REQ-036 en_i dropped for 5 cycles between two edges, then an edge -> no push (IDLE re-entry); the next edge pushes the correct length.
REQ-037 clr_i asserted with 3 entries, overflow_o=1 and a same-cycle edge -> next cycle meas_valid_o=0, overflow_o=0, state IDLE.
